// File: rtl/sparse_row_encoder_pkg.sv
// Shared constants and types for the sparse row encoder and its IND FIFO link.
package sparse_row_encoder_pkg;

   localparam int N   = 4;
   localparam int DW  = 16;
   localparam int IND = $clog2(N);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } enc_state_t;

   typedef struct packed {
      logic [DW-1:0]  val;
      logic [IND-1:0] ind;
      logic           ends;
   } ind_entry_t;

endpackage

// File: rtl/sparse_row_encoder_if.sv
// Dense-row input handshake plus the IND FIFO load port of one encoder.
interface sparse_row_encoder_if #(
   parameter int N   = sparse_row_encoder_pkg::N,
   parameter int DW  = sparse_row_encoder_pkg::DW,
   parameter int IND = sparse_row_encoder_pkg::IND
);
   // A row transfers on the rising edge where in_valid && in_ready; in_row is
   // sampled only then. load writes one entry per edge; stall asks the encoder
   // to hold off issuing further entries.
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] in_row;
   logic            stall;
   logic            load;
   logic [DW-1:0]   load_vals;
   logic [IND-1:0]  load_inds;
   logic            load_ends;
   logic            row_done;

   modport master (
      input  in_valid, in_row, stall,
      output in_ready, load, load_vals, load_inds, load_ends, row_done
   );

   modport slave (
      output in_valid, in_row, stall,
      input  in_ready, load, load_vals, load_inds, load_ends, row_done
   );
endinterface

// File: rtl/sparse_row_encoder_lsb_priority_enc.sv
// Combinational lowest-set-bit finder; one_hot flags a single remaining bit.
module lsb_priority_enc #(
   parameter int N   = 4,
   parameter int IND = $clog2(N)
) (
   input  logic [N-1:0]   mask_i,
   output logic [IND-1:0] idx_o,
   output logic           any_o,
   output logic           one_hot_o
);
   always_comb begin
      idx_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask_i[i]) idx_o = IND'(i);
      end
   end

   assign any_o     = |mask_i;
   assign one_hot_o = any_o && ((mask_i & (mask_i - N'(1))) == '0);
endmodule

// File: rtl/sparse_row_encoder.sv
// Compresses one dense row per handshake into (value, index, end) IND FIFO entries.
// SPARSE_ENC_BACK2BACK_EN: accept the next row during the final entry (no bubble).
module sparse_row_encoder #(
   parameter int N   = sparse_row_encoder_pkg::N,
   parameter int DW  = sparse_row_encoder_pkg::DW,
   parameter int IND = $clog2(N)
) (
   input  logic                              CLK,
   input  logic                              nRST,
   sparse_row_encoder_if.master              bus,
   output sparse_row_encoder_pkg::enc_state_t dbg_state_o
);
   import sparse_row_encoder_pkg::*;

   enc_state_t      state_q;
   logic [N*DW-1:0] row_q;
   logic [N-1:0]    mask_q, mask_d;
   ind_entry_t      ent_q;
   logic            load_q, done_q;

   logic            accept, issue;
   logic [N*DW-1:0] src_row;
   logic [N-1:0]    new_mask, src_mask;
   logic [DW-1:0]   elem [N];
   logic [IND-1:0]  p;
   logic            any, last;

`ifdef SPARSE_ENC_BACK2BACK_EN
   assign bus.in_ready = nRST && ((state_q == IDLE) ||
                                  ((state_q == SCAN) && (mask_q == '0) && !bus.stall));
`else
   assign bus.in_ready = nRST && (state_q == IDLE);
`endif

   assign accept = bus.in_valid && bus.in_ready;

   // An all-zero row still needs a terminator, so it becomes a mask on element 0.
   always_comb begin
      new_mask = '0;
      for (int i = 0; i < N; i++) new_mask[i] = |bus.in_row[i*DW +: DW];
      if (new_mask == '0) new_mask = N'(1);
   end

   assign src_mask = accept ? new_mask : mask_q;
   assign src_row  = accept ? bus.in_row : row_q;

   for (genvar g = 0; g < N; g++) begin : g_elem
      assign elem[g] = src_row[g*DW +: DW];
   end

   lsb_priority_enc #(.N(N), .IND(IND)) u_pe (
      .mask_i    (src_mask),
      .idx_o     (p),
      .any_o     (any),
      .one_hot_o (last)
   );

   assign issue  = (accept || (state_q == SCAN)) && any && !bus.stall;
   assign mask_d = issue ? (src_mask & ~(N'(1) << p)) : src_mask;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         row_q   <= '0;
         mask_q  <= '0;
         ent_q   <= '0;
         load_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         load_q <= issue;
         done_q <= issue && last;
         if (issue) ent_q <= '{val: elem[p], ind: p, ends: last};
         if (accept) begin
            row_q   <= bus.in_row;
            mask_q  <= mask_d;
            state_q <= SCAN;
         end else if (state_q == SCAN) begin
            mask_q <= mask_d;
            // Empty mask means the end entry is already on the outputs.
            if (!any) state_q <= IDLE;
         end
      end
   end

   assign bus.load      = load_q;
   assign bus.load_vals = ent_q.val;
   assign bus.load_inds = ent_q.ind;
   assign bus.load_ends = ent_q.ends;
   assign bus.row_done  = done_q;
   assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_sparse_row_encoder.sv
// Bench for sparse_row_encoder: directed table, multi-cycle corner sequences, random rows.
module tb_sparse_row_encoder;
  import sparse_row_encoder_pkg::*;

  localparam int W = DW + IND + 1;
`ifdef SPARSE_ENC_BACK2BACK_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 1;
`endif

  typedef struct {
    logic [N*DW-1:0] row;
    int              cnt;
    logic [W-1:0]    ent [N];
  } vec_t;

  logic       CLK = 1'b0;
  logic       nRST;
  enc_state_t dbg_state;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         mon_en = 0;
  logic [W-1:0] exp_q[$];
  vec_t       vecs [5];

  sparse_row_encoder_if bus ();

  sparse_row_encoder dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] cur_entry();
    return {bus.load_vals, bus.load_inds, bus.load_ends};
  endfunction

  // reference model: non-zero elements in ascending index order, last one flagged
  task automatic model_row(input logic [N*DW-1:0] row);
    logic [W-1:0]  lst[$];
    logic [W-1:0]  e;
    logic [DW-1:0] v;
    for (int i = 0; i < N; i++) begin
      v = row[i*DW +: DW];
      if (v != '0) lst.push_back({v, IND'(i), 1'b0});
    end
    if (lst.size() == 0) lst.push_back({DW'(0), IND'(0), 1'b1});
    else begin
      e = lst.pop_back();
      e[0] = 1'b1;
      lst.push_back(e);
    end
    foreach (lst[k]) exp_q.push_back(lst[k]);
  endtask

  function automatic logic [N*DW-1:0] rand_row();
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++)
      r[i*DW +: DW] = ($urandom_range(0, 1) == 0) ? DW'(0) : DW'($urandom_range(1, 65535));
    return r;
  endfunction

  // scoreboard monitor
  always @(negedge CLK) begin
    if (mon_en) begin
      if (bus.load) begin
        check("load_in_scan", dbg_state, SCAN);
        check("done_eq_ends", bus.row_done, bus.load_ends);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_load: got entry %0h expected none", cur_entry());
        end else begin
          check("rand_entry", cur_entry(), exp_q.pop_front());
        end
      end else begin
        check("done_without_load", bus.row_done, 1'b0);
      end
    end
  end

  // driver: one table row, then its entries on consecutive cycles
  task automatic apply_vec(input int v);
    @(negedge CLK);
    bus.in_row   = vecs[v].row;
    bus.in_valid = 1'b1;
    bus.stall    = 1'b0;
    #1 check("vec_ready", bus.in_ready, 1'b1);
    @(negedge CLK);
    bus.in_valid = 1'b0;
    for (int j = 0; j < vecs[v].cnt; j++) begin
      if (j > 0) @(negedge CLK);
      check("vec_load", bus.load, 1'b1);
      check("vec_entry", cur_entry(), vecs[v].ent[j]);
      check("vec_row_done", bus.row_done, vecs[v].ent[j][0]);
    end
    @(negedge CLK);
    check("vec_load_after", bus.load, 1'b0);
    check("vec_ready_after", bus.in_ready, 1'b1);
  endtask

  initial begin
    logic [N*DW-1:0] row_a, row_b, cur;
    int lc [8];
    logic [W-1:0] le [8];
    int nl, acc, rows_left;

    vecs[0].row = {16'd3, 16'd0, 16'd7, 16'd0};
    vecs[0].cnt = 2;
    vecs[0].ent[0] = {16'd7, 2'd1, 1'b0};
    vecs[0].ent[1] = {16'd3, 2'd3, 1'b1};
    vecs[1].row = '0;
    vecs[1].cnt = 1;
    vecs[1].ent[0] = {16'd0, 2'd0, 1'b1};
    vecs[2].row = {16'd4, 16'd3, 16'd2, 16'd1};
    vecs[2].cnt = 4;
    vecs[2].ent[0] = {16'd1, 2'd0, 1'b0};
    vecs[2].ent[1] = {16'd2, 2'd1, 1'b0};
    vecs[2].ent[2] = {16'd3, 2'd2, 1'b0};
    vecs[2].ent[3] = {16'd4, 2'd3, 1'b1};
    vecs[3].row = {16'd8, 16'd0, 16'd0, 16'd0};
    vecs[3].cnt = 1;
    vecs[3].ent[0] = {16'd8, 2'd3, 1'b1};
    vecs[4].row = {16'd0, 16'd0, 16'd0, 16'd9};
    vecs[4].cnt = 1;
    vecs[4].ent[0] = {16'd9, 2'd0, 1'b1};

    // reset with in_valid held high
    nRST = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_row = vecs[2].row;
    bus.stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("rst_load", bus.load, 1'b0);
      check("rst_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    nRST = 1'b1;
    @(negedge CLK);
    check("idle_ready", bus.in_ready, 1'b1);
    check("idle_state", dbg_state, IDLE);
    check("idle_load", bus.load, 1'b0);
    check("idle_vals", bus.load_vals, '0);
    @(negedge CLK);
    check("idle_no_take", dbg_state, IDLE);
    check("idle_load2", bus.load, 1'b0);

    for (int v = 0; v < 5; v++) apply_vec(v);

    // stall for two cycles after the first entry
    @(negedge CLK);
    bus.in_row = {16'd0, 16'd9, 16'd0, 16'd5};
    bus.in_valid = 1'b1;
    @(negedge CLK);
    bus.in_valid = 1'b0;
    check("stall_first_load", bus.load, 1'b1);
    check("stall_first_entry", cur_entry(), {16'd5, 2'd0, 1'b0});
    bus.stall = 1'b1;
    @(negedge CLK);
    check("stall_gap1", bus.load, 1'b0);
    @(negedge CLK);
    check("stall_gap2", bus.load, 1'b0);
    bus.stall = 1'b0;
    @(negedge CLK);
    check("stall_second_load", bus.load, 1'b1);
    check("stall_second_entry", cur_entry(), {16'd9, 2'd2, 1'b1});
    check("stall_row_done", bus.row_done, 1'b1);
    @(negedge CLK);
    check("stall_no_dup", bus.load, 1'b0);

    // reset in the middle of a row
    @(negedge CLK);
    bus.in_row = vecs[2].row;
    bus.in_valid = 1'b1;
    @(negedge CLK);
    bus.in_valid = 1'b0;
    check("mid_first", cur_entry(), vecs[2].ent[0]);
    @(negedge CLK);
    check("mid_second", cur_entry(), vecs[2].ent[1]);
    #1 nRST = 1'b0;
    #1;
    check("mid_rst_load", bus.load, 1'b0);
    check("mid_rst_entry", cur_entry(), '0);
    check("mid_rst_done", bus.row_done, 1'b0);
    check("mid_rst_state", dbg_state, IDLE);
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("mid_no_end", bus.load, 1'b0);
    end
    apply_vec(0);

    // two rows with in_valid held high
    row_a = vecs[0].row;
    row_b = {16'd0, 16'd0, 16'd0, 16'd1};
    nl = 0;
    acc = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      if (bus.load && nl < 8) begin
        lc[nl] = c;
        le[nl] = cur_entry();
        nl++;
      end
      bus.in_row = (acc == 0) ? row_a : row_b;
      bus.in_valid = (acc < 2);
      #1;
      if (bus.in_valid && bus.in_ready) acc++;
    end
    check("b2b_accepts", acc, 2);
    check("b2b_entries", nl, 3);
    if (nl == 3) begin
      check("b2b_a0", le[0], {16'd7, 2'd1, 1'b0});
      check("b2b_a1", le[1], {16'd3, 2'd3, 1'b1});
      check("b2b_b0", le[2], {16'd1, 2'd0, 1'b1});
      check("b2b_gap", lc[2] - lc[1] - 1, GAP);
    end

    // random rows with random stall against the model
    mon_en = 1;
    rows_left = 60;
    cur = rand_row();
    for (int c = 0; c < 4000 && rows_left > 0; c++) begin
      @(negedge CLK);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_row = cur;
      #1;
      if (bus.in_valid && bus.in_ready) begin
        model_row(cur);
        rows_left--;
        cur = rand_row();
      end
    end
    @(negedge CLK);
    bus.in_valid = 1'b0;
    bus.stall = 1'b0;
    check("rand_all_sent", rows_left, 0);
    repeat (3 * N + 4) @(negedge CLK);
    check("rand_drained", exp_q.size(), 0);
    mon_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sparse_row_encoder.md
Name: sparse_row_encoder

Overview:
- Producer side of the index-FIFO protocol. Accepts one dense matrix row per handshake and compresses it into a stream of non-zero (value, index) entries.
- Drives the load / load_vals / load_inds / load_ends inputs of one IND FIFO.
- One instance per array row/column feeder, sitting between the operand buffer and the IND FIFO.
- Emits at most one entry per cycle. The last entry of each row carries the end flag.

Parameters:
- N, 4, elements per dense row (array dimension); power of two, >= 2.
- DW, 16, element width; must equal the package DW.
- IND, $clog2(N), index width; must equal the package IND.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- in_valid  in  1  dense row available.
- in_ready  out  1  encoder can accept a row.
- in_row  in  N*DW  dense row; element i occupies bits [i*DW +: DW].
- stall  in  1  IND FIFO cannot take an entry this cycle; holds the encoder.
- load  out  1  write strobe to the IND FIFO.
- load_vals  out  DW  non-zero element value.
- load_inds  out  IND  column index of load_vals.
- load_ends  out  1  high on the last entry of the row.
- row_done  out  1  one-cycle pulse when a row's final entry is written.

Behaviour:
- Reset (nRST low, asynchronous): state=IDLE. in_ready=0 while nRST is low, then 1 in IDLE. load=0, load_vals=0, load_inds=0, load_ends=0, row_done=0. Row register and mask cleared.
- Reset mid-row discards the partial row. No end entry is emitted for it.
- States:
  - IDLE: in_ready=1. On in_valid && in_ready: latch in_row; build mask[i] = (elem i != 0); go to SCAN.
  - SCAN: p = lowest set bit of mask.
    - If !stall: load=1, load_vals=elem p, load_inds=p, load_ends=(mask has exactly one bit set); clear mask[p].
    - If this was the last bit: row_done=1 and go to IDLE. Otherwise stay in SCAN.
  - stall high in SCAN: load=0, no state or mask change. Outputs other than load are don't-care but must hold their last values.
- Outputs are combinational from registered state only (Moore). There is no path from stall or in_valid to load.
- Latency: the first load is asserted in the cycle after the acceptance edge.
- Throughput: one entry per unstalled cycle. A row with k non-zeros takes k SCAN cycles plus one IDLE cycle (see the optional feature).
- All-zero row: emit exactly one entry with value 0, index 0, ends=1, plus row_done. The consumer always sees a row terminator.
- Entries are emitted in strictly ascending index order.
- Full row (all non-zero): N entries with indices 0..N-1; ends only on index N-1.
- in_row is sampled only at acceptance. Changes to in_row during SCAN are ignored.
- load is never asserted in IDLE.

Optional Feature:
- Macro: SPARSE_ENC_BACK2BACK_EN.
- Defined:
  - in_ready is also asserted in SCAN when the current entry is the last one (load_ends=1) and stall=0.
  - A row accepted on that edge goes straight to SCAN, so rows stream with no bubble.
  - The all-zero-row rule still applies to the new row.
- Undefined: in_ready=1 only in IDLE, giving exactly one bubble cycle between rows.

Decomposition:
- sys_arr_pkg:
  - constants DW, IND, N (array dim).
  - typedef enc_state_t {IDLE, SCAN}.
  - typedef struct ind_entry_t {val[DW], ind[IND], ends}.
- Sub-module: lsb_priority_enc (N-bit mask in; IND-bit index of lowest set bit, any, and one_hot flag out).
  - one_hot is used for load_ends.
  - It is purely combinational; all sequencing stays in sparse_row_encoder.

Test Plan:
- Reset and idle: hold nRST low 3 cycles with in_valid=1 -> load=0, in_ready=0. After release: in_ready=1 and no row taken before an in_valid edge in IDLE.
- Sparse row: N=4, row {0,7,0,3}, stall=0 -> (7,1,ends0) then (3,3,ends1). row_done on the second entry. in_ready returns 1 the next cycle.
- All-zero row: {0,0,0,0} -> a single (0,0,ends1) with row_done. Full row {1,2,3,4} -> 4 entries, indices 0..3, ends only on index 3.
- Stall: row {5,0,9,0}, stall high for 2 cycles after the first entry -> load low for 2 cycles. The second entry (9,2,ends1) is emitted after stall drops, with no duplicate or lost entries.
- Mid-row reset: row {1,2,3,4}, pulse nRST low after the second entry -> outputs zero immediately, state IDLE, no ends entry. The next row encodes correctly.
- Back-to-back: two rows with in_valid held high -> exactly 1 idle cycle between row 1's ends and row 2's first entry with SPARSE_ENC_BACK2BACK_EN undefined; 0 cycles when defined.
